// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: round-robin share of one APB master (HCLK/HRESETn, req_* requester side, P* APB side, grant_id/busy status); define APB_TIMEOUT_EN for the ACCESS wait-state timeout
module apb_rr_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_err,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t r_state;
  logic [IW-1:0] r_ptr, w_win;
  logic [NUM_REQ-1:0] w_rot;
  logic w_to, w_end, w_done;
  always_comb begin
    w_rot = NUM_REQ'({req_valid, req_valid} >> (r_ptr + 1'b1));
    w_win = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      w_win = w_rot[j] ? IW'((int'(r_ptr) + 1 + j) % NUM_REQ) : w_win;
  end
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) r_cnt <= '0;
    else r_cnt <= r_state != ACCESS ? '0 : r_cnt + CW'(!PREADY);
  assign w_to = r_state == ACCESS && !PREADY && r_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0;
`endif
  assign w_end = PREADY | w_to;
  assign w_done = r_state == ACCESS && w_end;
  assign req_done = w_done ? NUM_REQ'(1) << grant_id : '0;
  assign req_rdata = (w_done && !PWRITE && !w_to) ? PRDATA : '0;
  assign req_err = w_done && (PSLVERR || w_to);
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      r_state <= IDLE;
      r_ptr <= IW'(NUM_REQ - 1);
      grant_id <= '0;
      busy <= 1'b0;
      PSEL <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
    end else
      case (r_state)
        IDLE:
          if (|req_valid) begin
            grant_id <= w_win;
            r_ptr <= w_win;
            PADDR <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
            PWDATA <= req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
            PWRITE <= req_write[w_win];
            PSEL <= 1'b1;
            busy <= 1'b1;
            r_state <= SETUP;
          end
        SETUP: begin
          PENABLE <= 1'b1;
          r_state <= ACCESS;
        end
        ACCESS:
          if (w_end) begin
            PSEL <= 1'b0;
            PENABLE <= 1'b0;
            busy <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb_apb_rr_master_arbiter: directed and randomized transfers checked against a transaction-level round-robin model
module tb_apb_rr_master_arbiter;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic [3:0] req_valid, req_write, req_done;
  logic [127:0] req_addr, req_wdata;
  logic [31:0] req_rdata, PADDR, PWDATA, PRDATA;
  logic [1:0] grant_id;
  logic req_err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  int checks = 0, errors = 0, last = 3;
  apb_rr_master_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata),
    .req_err(req_err), .grant_id(grant_id), .busy(busy), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  function automatic int rr_next();
    for (int k = 1; k <= 4; k++)
      if (req_valid[(last + k) % 4]) return (last + k) % 4;
    return 0;
  endfunction
  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*32 +: 32] = a;
    req_wdata[i*32 +: 32] = d;
  endtask
  task automatic xfer(input int waits, input logic serr, input logic [31:0] rd, input logic drop, input logic to);
    int id;
    logic [31:0] ea, ed;
    logic ew;
    id = rr_next();
    ea = req_addr[id*32 +: 32];
    ed = req_wdata[id*32 +: 32];
    ew = req_write[id];
    #4;
    chk("idle_psel", PSEL, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", req_done, 0);
    tick();
    if (drop) req_valid[id] = 1'b0;
    for (int i = 0; i < 4; i++)
      if (i != id) begin
        req_addr[i*32 +: 32] = $urandom;
        req_wdata[i*32 +: 32] = $urandom;
        req_write[i] = 1'($urandom);
      end
    #4;
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_busy", busy, 1);
    chk("grant_id", grant_id, id);
    chk("setup_paddr", PADDR, ea);
    chk("setup_pwrite", PWRITE, ew);
    chk("setup_pwdata", PWDATA, ed);
    chk("setup_done", req_done, 0);
    for (int w = 0; w <= waits; w++) begin
      tick();
      PREADY = (w == waits) && !to;
      PRDATA = (w == waits) ? rd : $urandom;
      PSLVERR = (w == waits) ? serr : 1'($urandom);
      #4;
      chk("access_psel", PSEL, 1);
      chk("access_penable", PENABLE, 1);
      chk("access_busy", busy, 1);
      chk("access_paddr", PADDR, ea);
      chk("access_pwrite", PWRITE, ew);
      chk("access_pwdata", PWDATA, ed);
      chk("req_done", req_done, w == waits ? 4'(1 << id) : 4'b0);
      if (w == waits) begin
        chk("req_rdata", req_rdata, (ew || to) ? 32'h0 : rd);
        chk("req_err", req_err, serr || to);
      end else
        chk("wait_err", req_err, 0);
    end
    tick();
    req_valid[id] = 1'b0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    last = id;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    req_valid = 4'hF;
    req_write = 4'hF;
    req_addr = '1;
    req_wdata = '1;
    PRDATA = '1;
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    #3;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_err", req_err, 0);
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    PRDATA = '0;
    PREADY = 1'b0;
    PSLVERR = 1'b0;
    tick();
    HRESETn = 1'b1;
    tick();
    set_req(0, 1'b0, 32'h1000, 32'h0);
    xfer(0, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0);
    chk("read_psel_drop", PSEL, 0);
    chk("gid_hold", grant_id, 0);
    chk("paddr_hold", PADDR, 32'h1000);
    set_req(2, 1'b1, 32'h2004, 32'hDEAD_BEEF);
    xfer(3, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("write_gid", grant_id, 2);
    chk("pwdata_hold", PWDATA, 32'hDEAD_BEEF);
    set_req(1, 1'b0, 32'h3000, 32'h0);
    xfer(0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("slverr_gid", grant_id, 1);
    set_req(3, 1'b0, 32'h4000, 32'h0);
    xfer(1, 1'b0, $urandom, 1'b1, 1'b0);
    chk("drop_gid", grant_id, 3);
    for (int i = 0; i < 4; i++) set_req(i, 1'($urandom), $urandom, $urandom);
    for (int k = 0; k < 8; k++) begin
      xfer(k % 3, 1'b0, $urandom, 1'b0, 1'b0);
      chk("rr_seq", grant_id, k % 4);
      req_valid = 4'hF;
    end
    req_valid = 4'b0100;
    tick();
    tick();
    PREADY = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("arst_psel", PSEL, 0);
    chk("arst_penable", PENABLE, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", req_done, 0);
    chk("arst_grant", grant_id, 0);
    chk("arst_paddr", PADDR, 0);
    tick();
    HRESETn = 1'b1;
    last = 3;
    req_valid = 4'hF;
    xfer(1, 1'b0, $urandom, 1'b0, 1'b0);
    chk("arst_first_win", grant_id, 0);
    req_valid = '0;
`ifdef APB_TIMEOUT_EN
    set_req(1, 1'b0, 32'h5000, 32'h0);
    xfer(15, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
    chk("timeout_idle", PSEL, 0);
    set_req(1, 1'b0, 32'h5004, 32'h0);
    xfer(15, 1'b0, 32'h0BAD_F00D, 1'b0, 1'b0);
`endif
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 1'($urandom), $urandom, $urandom);
      if (req_valid == 4'b0) req_valid[$urandom_range(0, 3)] = 1'b1;
      xfer($urandom_range(0, 4), $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 7) == 0, 1'b0);
    end
    req_valid = '0;
    tick();
    #4;
    chk("final_psel", PSEL, 0);
    chk("final_done", req_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ local requesters, e.g. AHB-to-APB bridge instances and a DMA/config engine.
- Arbitrates round-robin and latches the winner's command.
- Sequences the APB SETUP/ACCESS phases with PREADY wait states.
- Returns completion, read data and error to the granted requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, APB address width
- DATA_WIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN

Ports:
- HCLK  in  1  clock, single clock domain
- HRESETn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request; held high until that requester's req_done
- req_write  in  NUM_REQ  1=write, 0=read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
- req_done  out  NUM_REQ  one-cycle completion strobe, one-hot
- req_rdata  out  DATA_WIDTH  read data, valid while any req_done bit is high
- req_err  out  1  error flag, valid while any req_done bit is high
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
- busy  out  1  high in SETUP and ACCESS
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH  APB address
- PWDATA  out  DATA_WIDTH  APB write data
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY, PSLVERR  in  1  APB completion and error

Behaviour:
- Reset values:
  - All outputs are 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, grant_id, busy, req_done, req_rdata, req_err.
  - Round-robin pointer resets to NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise select the first set bit searching from pointer+1 upward, wrapping modulo NUM_REQ.
  - Register grant_id and the pointer to the winner.
  - Latch the winner's addr/write/wdata into PADDR/PWRITE/PWDATA.
  - Go to SETUP.
- SETUP: PSEL=1, PENABLE=0, busy=1; unconditionally go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - If PREADY=0, hold state (wait states, unbounded unless the optional feature is enabled).
  - If PREADY=1, go to IDLE.
- Completion (combinational, in the ACCESS cycle where PREADY=1):
  - req_done[grant_id]=1.
  - req_rdata=PRDATA for reads, 0 for writes.
  - req_err=PSLVERR.
  - The requester deasserts req_valid at that edge.
- Output timing and stability:
  - PSEL/PENABLE/busy are registered.
  - PADDR/PWRITE/PWDATA do not change from SETUP through the end of ACCESS.
  - Those three retain their last values in IDLE; they are not cleared.
- Throughput:
  - Every transfer is followed by at least one IDLE cycle.
  - Minimum transfer is 3 cycles (IDLE, SETUP, ACCESS).
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 transfers.
- Requester changes:
  - Changes to req_* of non-granted requesters during a transfer have no effect.
  - Dropping req_valid of the granted requester mid-transfer does not abort the APB transfer; req_done still pulses.
- Reset mid-operation:
  - HRESETn low forces IDLE immediately (asynchronously).
  - All outputs return to reset values; no req_done is issued; the pointer is reinitialised.
- Invariants:
  - PENABLE implies PSEL.
  - PENABLE is never high in the cycle following PSEL's rising edge.
  - req_done is at most one-hot.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- When defined:
  - An ACCESS wait counter clears on entry to SETUP and increments each ACCESS cycle with PREADY=0.
  - If it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted that cycle: req_done[grant_id]=1, req_err=1, req_rdata=0.
  - Next state is IDLE; PSEL/PENABLE drop to 0.
  - PREADY=1 in the same cycle as the limit takes priority (normal completion).
- When undefined:
  - No counter logic is present.
  - ACCESS waits indefinitely for PREADY.

Test Plan:
- Single read: req_valid=4'b0001, addr 0x1000, PREADY=1 immediately, PRDATA=0xCAFE_0001 -> PSEL high 2 cycles, PENABLE 1 cycle, PADDR=0x1000, PWRITE=0; req_done=4'b0001 with req_rdata=0xCAFE_0001, req_err=0.
- Write with 3 wait states: requester 2, addr 0x2004, wdata 0xDEAD_BEEF, PREADY low 3 ACCESS cycles -> PENABLE high 4 cycles; PADDR/PWDATA stable throughout; req_done=4'b0100 on the 4th ACCESS cycle.
- Round-robin: all 4 requesters held valid for 8 transfers -> grant_id sequence 0,1,2,3,0,1,2,3; exactly one IDLE cycle between transfers.
- Slave error: PSLVERR=1 with PREADY=1 on a requester-1 read -> req_done=4'b0010, req_err=1.
- Async reset mid-ACCESS: HRESETn low during a wait state -> PSEL=PENABLE=busy=0 immediately; no req_done; after release, requester 0 wins first arbitration.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY held 0 -> abort after 16 ACCESS cycles with req_err=1, req_rdata=0, then IDLE; repeat with PREADY=1 on cycle 16 -> normal completion, req_err=0.
